alu_arbiter: RTL and testbench

- Shares one combinational base/extra ALU between two requesters: requester 0 is the execute stage, requester 1 is an auxiliary sequencer such as the address or branch unit.
- Arbitrates round-robin, registers the winner's funct3/funct7/operands onto the ALU inputs and holds them for ALU_LATENCY cycles.
- Captures the ALU result and returns it to the winning requester as a one-cycle response pulse.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered, held for ALU_LATENCY cycles, and the result is returned as a one-cycle pulse.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_funct3,
    input  logic [6:0]            req0_funct7,
    input  logic [DATA_WIDTH-1:0] req0_data_1,
    input  logic [DATA_WIDTH-1:0] req0_data_2,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_funct3,
    input  logic [6:0]            req1_funct7,
    input  logic [DATA_WIDTH-1:0] req1_data_1,
    input  logic [DATA_WIDTH-1:0] req1_data_2,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,

    output logic                  alu_enable,
    output logic [2:0]            alu_funct3,
    output logic [6:0]            alu_funct7,
    output logic [DATA_WIDTH-1:0] alu_data_1,
    output logic [DATA_WIDTH-1:0] alu_data_2,
    input  logic [DATA_WIDTH-1:0] alu_data_out,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       ptr;
    logic       owner;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       fire;

    // ptr = 0 favours requester 0 when both are valid
    always_comb begin
        grant0     = req0_valid && (!req1_valid || !ptr);
        grant1     = req1_valid && (!req0_valid ||  ptr);
        // ready is gated by reset so it reads 0 while reset is asserted
        req0_ready = reset_n && (state == IDLE) && grant0;
        req1_ready = reset_n && (state == IDLE) && grant1;
        fire       = req0_ready || req1_ready;

        alu_enable  = (state == EXEC);
        busy        = (state != IDLE);
        resp0_valid = (state == DONE) && !owner;
        resp1_valid = (state == DONE) &&  owner;

        state_next = state;
        case (state)
            IDLE:    if (fire) state_next = EXEC;
            EXEC:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            cnt        <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            alu_data_1 <= '0;
            alu_data_2 <= '0;
            resp0_data <= '0;
            resp1_data <= '0;
        end else begin
            state <= state_next;
            if (fire) begin
                owner      <= req1_ready;
                ptr        <= !req1_ready;
                cnt        <= CNT_LOAD;
                alu_funct3 <= req1_ready ? req1_funct3 : req0_funct3;
                alu_funct7 <= req1_ready ? req1_funct7 : req0_funct7;
                alu_data_1 <= req1_ready ? req1_data_1 : req0_data_1;
                alu_data_2 <= req1_ready ? req1_data_2 : req0_data_2;
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    if (owner) resp1_data <= alu_data_out;
                    else       resp0_data <= alu_data_out;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LATENCY=1, one with ALU_LATENCY=3,
// each fed by a small behavioural ALU; both share the requester inputs.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]   req0_funct3 = '0, req1_funct3 = '0;
    logic [6:0]   req0_funct7 = '0, req1_funct7 = '0;
    logic [W-1:0] req0_data_1 = '0, req0_data_2 = '0, req1_data_1 = '0, req1_data_2 = '0;

    logic         req0_ready, req1_ready, resp0_valid, resp1_valid, alu_enable, busy;
    logic [W-1:0] resp0_data, resp1_data, alu_data_1, alu_data_2, alu_data_out;
    logic [2:0]   alu_funct3;
    logic [6:0]   alu_funct7;

    logic         req0_ready_3, req1_ready_3, resp0_valid_3, resp1_valid_3, alu_enable_3, busy_3;
    logic [W-1:0] resp0_data_3, resp1_data_3, alu_data_1_3, alu_data_2_3, alu_data_out_3;
    logic [2:0]   alu_funct3_3;
    logic [6:0]   alu_funct7_3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    function automatic logic [W-1:0] alu_model(input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return a + b;
        endcase
    endfunction

    assign alu_data_out   = alu_model(alu_funct3, alu_funct7, alu_data_1, alu_data_2);
    assign alu_data_out_3 = alu_model(alu_funct3_3, alu_funct7_3, alu_data_1_3, alu_data_2_3);

    alu_arbiter #(.DATA_WIDTH(W), .ALU_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
        .req0_funct7(req0_funct7), .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
        .req1_funct7(req1_funct7), .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .alu_enable(alu_enable), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_data_out(alu_data_out),
        .busy(busy)
    );

    alu_arbiter #(.DATA_WIDTH(W), .ALU_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_3), .req0_funct3(req0_funct3),
        .req0_funct7(req0_funct7), .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
        .resp0_valid(resp0_valid_3), .resp0_data(resp0_data_3),
        .req1_valid(req1_valid), .req1_ready(req1_ready_3), .req1_funct3(req1_funct3),
        .req1_funct7(req1_funct7), .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
        .resp1_valid(resp1_valid_3), .resp1_data(resp1_data_3),
        .alu_enable(alu_enable_3), .alu_funct3(alu_funct3_3), .alu_funct7(alu_funct7_3),
        .alu_data_1(alu_data_1_3), .alu_data_2(alu_data_2_3), .alu_data_out(alu_data_out_3),
        .busy(busy_3)
    );

    task automatic apply_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, alu_enable, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid, alu_enable, busy});
        end
        n_checks++;
        if ({resp0_data, resp1_data, alu_data_1, alu_data_2, alu_funct3, alu_funct7} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h %h expected all 0",
                     resp0_data, resp1_data, alu_data_1, alu_data_2, alu_funct3, alu_funct7);
        end
        apply_reset();
    endtask

    task automatic test_single_add();
        apply_reset();
        @(negedge clock);
        req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_data_1 = 1; req0_data_2 = 2; req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clock);
        n_checks++;
        if ({alu_enable, busy, req0_ready, alu_data_1, alu_data_2} !== {1'b1, 1'b1, 1'b0, 32'd1, 32'd2}) begin
            n_fail++;
            $display("FAIL add_exec: got en=%b busy=%b rdy=%b d1=%0d d2=%0d expected 1 1 0 1 2",
                     alu_enable, busy, req0_ready, alu_data_1, alu_data_2);
        end
        req0_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({resp0_valid, resp1_valid, alu_enable, resp0_data} !== {3'b100, 32'h3}) begin
            n_fail++;
            $display("FAIL add_resp: got v0=%b v1=%b en=%b data=%h expected 1 0 0 00000003",
                     resp0_valid, resp1_valid, alu_enable, resp0_data);
        end
        @(negedge clock);
        n_checks++;
        if ({resp0_valid, busy, resp0_data} !== {2'b00, 32'h3}) begin
            n_fail++;
            $display("FAIL add_after: got v0=%b busy=%b data=%h expected 0 0 00000003",
                     resp0_valid, busy, resp0_data);
        end
    endtask

    task automatic test_subtract();
        apply_reset();
        @(negedge clock);
        req1_funct3 = 3'd0; req1_funct7 = 7'd32; req1_data_1 = 5; req1_data_2 = 7; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL sub_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clock);
        req1_valid = 1'b0;
        n_checks++;
        if ({alu_enable, alu_funct7} !== {1'b1, 7'd32}) begin
            n_fail++; $display("FAIL sub_funct7: got en=%b f7=%0d expected 1 32", alu_enable, alu_funct7);
        end
        @(negedge clock);
        n_checks++;
        if ({resp1_valid, resp0_valid, resp1_data} !== {2'b10, 32'hFFFF_FFFE}) begin
            n_fail++;
            $display("FAIL sub_resp: got v1=%b v0=%b data=%h expected 1 0 fffffffe",
                     resp1_valid, resp0_valid, resp1_data);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_d1;
        logic [W-1:0] exp_res;
        req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_data_1 = 0;  req0_data_2 = 1;
        req1_funct3 = 3'd0; req1_funct7 = 7'd0; req1_data_1 = 10; req1_data_2 = 20;
        reset_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_d1  = (i % 2 == 0) ? 32'd0 : 32'd10;
            exp_res = (i % 2 == 0) ? 32'd1 : 32'd30;
            n_checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL cont_grant%0d: got %b", i, {req0_ready, req1_ready});
            end
            @(negedge clock);
            n_checks++;
            if ({busy, req0_ready, req1_ready, alu_data_1} !== {3'b100, exp_d1}) begin
                n_fail++;
                $display("FAIL cont_exec%0d: got busy=%b rdy=%b%b d1=%0d expected 1 00 %0d",
                         i, busy, req0_ready, req1_ready, alu_data_1, exp_d1);
            end
            @(negedge clock);
            n_checks++;
            if ((i % 2 == 0) ? ({resp0_valid, resp1_valid, busy, req0_ready, req1_ready, resp0_data} !== {5'b10100, exp_res})
                             : ({resp0_valid, resp1_valid, busy, req0_ready, req1_ready, resp1_data} !== {5'b01100, exp_res})) begin
                n_fail++;
                $display("FAIL cont_resp%0d: got v=%b%b busy=%b d0=%0d d1=%0d expected result %0d",
                         i, resp0_valid, resp1_valid, busy, resp0_data, resp1_data, exp_res);
            end
            @(negedge clock);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_stability();
        apply_reset();
        @(negedge clock);
        req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_data_1 = 100; req0_data_2 = 5; req0_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready_3 !== 1'b1) begin
            n_fail++; $display("FAIL stab_ready: got %b expected 1", req0_ready_3);
        end
        // handshake on the next posedge; three EXEC cycles follow, response after the 3rd edge
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            req0_valid = 1'b0;
            n_checks++;
            if ({alu_enable_3, resp0_valid_3, alu_data_2_3} !== {2'b10, 32'd5}) begin
                n_fail++;
                $display("FAIL stab_exec%0d: got en=%b v=%b d2=%0d expected 1 0 5",
                         i, alu_enable_3, resp0_valid_3, alu_data_2_3);
            end
            req0_data_2 = 32'd1000 + 32'(i);
        end
        @(negedge clock);
        n_checks++;
        if ({resp0_valid_3, alu_enable_3, resp0_data_3} !== {2'b10, 32'd105}) begin
            n_fail++;
            $display("FAIL stab_resp: got v=%b en=%b data=%0d expected 1 0 105",
                     resp0_valid_3, alu_enable_3, resp0_data_3);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        @(negedge clock);
        req0_data_1 = 7; req0_data_2 = 8; req0_funct7 = 7'd0;
        req1_data_1 = 40; req1_data_2 = 2; req1_funct7 = 7'd0;
        req0_valid = 1'b1;
        @(negedge clock);
        req1_valid = 1'b1;
        n_checks++;
        if ({busy, alu_enable} !== 2'b11) begin
            n_fail++; $display("FAIL mid_exec: got busy=%b en=%b expected 1 1", busy, alu_enable);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, alu_enable, req0_ready, req1_ready, resp0_valid, resp1_valid, alu_data_1, resp0_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b en=%b rdy=%b%b v=%b%b d1=%0d r0=%0d expected all 0",
                     busy, alu_enable, req0_ready, req1_ready, resp0_valid, resp1_valid, alu_data_1, resp0_data);
        end
        @(negedge clock);
        n_checks++;
        if ({resp0_valid, resp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL mid_noresp: got %b expected 00", {resp0_valid, resp1_valid});
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL mid_ptr: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clock);
        n_checks++;
        if (alu_data_1 !== 32'd7) begin
            n_fail++; $display("FAIL mid_regrant: got d1=%0d expected 7", alu_data_1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_idle();
        int bad;
        apply_reset();
        @(negedge clock);
        req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_data_1 = 1; req0_data_2 = 2; req0_valid = 1'b1;
        @(negedge clock);
        req0_valid = 1'b0;
        repeat (2) @(negedge clock);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({busy, alu_enable, resp0_valid, resp1_valid, resp0_data, alu_data_1} !== {4'b0000, 32'd3, 32'd1})
                bad++;
            @(negedge clock);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_hold: got %0d bad cycles (busy=%b en=%b r0=%0d d1=%0d) expected 0",
                     bad, busy, alu_enable, resp0_data, alu_data_1);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL idle_ptr: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_subtract();
        test_contention();
        test_stability();
        test_reset_midop();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
